// File: rtl/mem_arbiter_if.sv
// Requester/memory bus for mem_arbiter: two requester ports and one memory port.
// The arbiter uses the slave modport; the requester/memory environment uses master.
interface mem_arbiter_if #(
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned ADDRESS_SIZE = 16
);
    logic [1:0]              req_en;
    logic [1:0]              req_rnw;
    logic [ADDRESS_SIZE-1:0] req_addr0;
    logic [ADDRESS_SIZE-1:0] req_addr1;
    logic [WORD_SIZE-1:0]    req_wdata0;
    logic [WORD_SIZE-1:0]    req_wdata1;
    logic [WORD_SIZE-1:0]    req_rdata;
    logic [1:0]              req_ready;

    logic                    mem_en;
    logic                    mem_rnw;
    logic [ADDRESS_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0]    mem_wdata;
    logic                    mem_wdata_oe;
    logic [WORD_SIZE-1:0]    mem_rdata;
    logic                    mem_ready;

    logic [1:0]              grant;
    logic                    timeout_err;

    modport slave (
        input  req_en, req_rnw, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  mem_rdata, mem_ready,
        output req_rdata, req_ready,
        output mem_en, mem_rnw, mem_addr, mem_wdata, mem_wdata_oe,
        output grant, timeout_err
    );

    modport master (
        output req_en, req_rnw, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output mem_rdata, mem_ready,
        input  req_rdata, req_ready,
        input  mem_en, mem_rnw, mem_addr, mem_wdata, mem_wdata_oe,
        input  grant, timeout_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter onto a single-port memory with BUSY timeout abort.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise requester 0 has fixed priority.
module mem_arbiter #(
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned ADDRESS_SIZE = 16,
    parameter int unsigned TIMEOUT      = 16
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    win_q, win_d;
    logic [1:0]              grant_q, grant_d;
    logic [1:0]              req_ready_q, req_ready_d;
    logic [WORD_SIZE-1:0]    rdata_q, rdata_d;
    logic                    mem_en_q, mem_en_d;
    logic                    mem_rnw_q, mem_rnw_d;
    logic [ADDRESS_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0]    mem_wdata_q, mem_wdata_d;
    logic                    oe_q, oe_d;
    logic                    timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    pick;
    logic                    finish;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                    ptr_q, ptr_d;
`endif

    // Winner selection: only consulted in IDLE when at least one request is up.
    always_comb begin
        pick = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (&bus.req_en) begin
            pick = ptr_q;
        end else begin
            pick = bus.req_en[1];
        end
`else
        pick = ~bus.req_en[0];
`endif
    end

    always_comb begin
        state_d       = state_q;
        win_d         = win_q;
        grant_d       = grant_q;
        req_ready_d   = '0;
        rdata_d       = rdata_q;
        mem_en_d      = mem_en_q;
        mem_rnw_d     = mem_rnw_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        oe_d          = oe_q;
        timeout_err_d = 1'b0;
        cnt_d         = '0;
        finish        = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        ptr_d         = ptr_q;
`endif

        case (state_q)
            IDLE: begin
                if (|bus.req_en) begin
                    state_d     = BUSY;
                    win_d       = pick;
                    grant_d     = pick ? 2'b10 : 2'b01;
                    mem_en_d    = 1'b1;
                    mem_rnw_d   = bus.req_rnw[pick];
                    mem_addr_d  = pick ? bus.req_addr1 : bus.req_addr0;
                    mem_wdata_d = pick ? bus.req_wdata1 : bus.req_wdata0;
                    oe_d        = ~bus.req_rnw[pick];
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    finish  = 1'b1;
                    rdata_d = mem_rnw_q ? bus.mem_rdata : '0;
                end else if (cnt_q == CNT_LAST) begin
                    finish        = 1'b1;
                    timeout_err_d = 1'b1;
                    rdata_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Normal completion and timeout abort share the same hand-back path.
        if (finish) begin
            state_d     = RELEASE;
            req_ready_d = win_q ? 2'b10 : 2'b01;
            grant_d     = '0;
            mem_en_d    = 1'b0;
            oe_d        = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_d       = ~win_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            win_q         <= 1'b0;
            grant_q       <= '0;
            req_ready_q   <= '0;
            rdata_q       <= '0;
            mem_en_q      <= 1'b0;
            mem_rnw_q     <= 1'b1;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            oe_q          <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            win_q         <= win_d;
            grant_q       <= grant_d;
            req_ready_q   <= req_ready_d;
            rdata_q       <= rdata_d;
            mem_en_q      <= mem_en_d;
            mem_rnw_q     <= mem_rnw_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            oe_q          <= oe_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_q         <= ptr_d;
`endif
        end
    end

    assign bus.grant        = grant_q;
    assign bus.req_ready    = req_ready_q;
    assign bus.req_rdata    = rdata_q;
    assign bus.mem_en       = mem_en_q;
    assign bus.mem_rnw      = mem_rnw_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_wdata_oe = oe_q;
    assign bus.timeout_err  = timeout_err_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32: data width in bits.
REQ-002 SHALL have parameter ADDRESS_SIZE, default 16: address width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum BUSY cycles before abort, minimum 2.
REQ-004 SHALL have ports: clk  in  1  single clock; all logic on posedge.
REQ-005 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: req_en[1:0]  in  2  per-requester access request (0 = data port, 1 = fetch port).
REQ-007 SHALL have ports: req_rnw[1:0]  in  2  per-requester 1 = read, 0 = write.
REQ-008 SHALL have ports: req_addr0, req_addr1  in  ADDRESS_SIZE each  request addresses.
REQ-009 SHALL have ports: req_wdata0, req_wdata1  in  WORD_SIZE each  write data.
REQ-010 SHALL have ports: req_rdata  out  WORD_SIZE  read data, shared, qualified by req_ready.
REQ-011 SHALL have ports: req_ready[1:0]  out  2  one-cycle completion pulse per requester.
REQ-012 SHALL have ports: mem_en, mem_rnw  out  1 each  memory ENABLE and READNOTWRITE.
REQ-013 SHALL have ports: mem_addr  out  ADDRESS_SIZE; mem_wdata  out  WORD_SIZE; mem_wdata_oe  out  1  tristate drive enable for INOUT_DATA.
REQ-014 SHALL have ports: mem_rdata  in  WORD_SIZE; mem_ready  in  1  memory DATA_READY.
REQ-015 SHALL have ports: grant[1:0]  out  2  one-hot owner, 00 when idle; timeout_err  out  1  one-cycle abort pulse.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, RELEASE.
REQ-017 IDLE: if any req_en high, SHALL select a winner, latch its rnw/addr/wdata, set grant, go BUSY next cycle.
REQ-018 BUSY: SHALL drive mem_en=1 and latched mem_rnw/mem_addr/mem_wdata; mem_wdata_oe=1 only when latched rnw=0.
REQ-019 BUSY with mem_ready=1: SHALL register mem_rdata (reads) or 0 (writes) into req_rdata, pulse the winner's req_ready for exactly one cycle, go RELEASE.
REQ-020 RELEASE: SHALL drive mem_en=0, mem_wdata_oe=0, grant=00 for exactly one cycle, then go IDLE.
REQ-021 Latency: request sampled in IDLE cycle N -> mem_en high from N+1 -> req_ready the cycle after mem_ready is first seen high.
REQ-022 Latched fields SHALL NOT change during BUSY regardless of requester inputs.
REQ-023 Requester dropping req_en during BUSY: transaction SHALL still complete and req_ready SHALL still pulse.
REQ-024 BUSY cycle counter SHALL count from 0; if it reaches TIMEOUT-1 with mem_ready=0, SHALL pulse timeout_err and req_ready, set req_rdata=0, go RELEASE.
REQ-025 mem_ready high outside BUSY SHALL be ignored.
REQ-026 Both req_en high in IDLE: winner chosen per REQ-031/032; loser stays pending and is served in the next IDLE if still requesting.
REQ-027 req_ready SHALL never be high for both requesters in the same cycle.

Reset
REQ-028 rst low SHALL asynchronously force state IDLE, grant=00, req_ready=00, req_rdata=0, mem_en=0, mem_rnw=1, mem_addr=0, mem_wdata=0, mem_wdata_oe=0, timeout_err=0, counter=0, priority pointer=0.
REQ-029 Reset asserted mid-BUSY SHALL abort the transaction without a req_ready pulse.
REQ-030 After rst release, first grant SHALL occur no earlier than the first posedge with rst high.

Configuration
REQ-031 Macro MEM_ARB_ROUND_ROBIN_EN defined: on contention, SHALL grant the requester not served last (pointer toggles on every completion, including timeout).
REQ-032 Macro undefined: on contention, SHALL always grant requester 0 (fixed priority); no pointer state.

Verification
REQ-033 Single read: req_en=01, rnw=1, addr0=0x0010, memory returns 0xDEADBEEF after 2 cycles -> grant=01, req_ready=01 one cycle, req_rdata=0xDEADBEEF.
REQ-034 Single write: requester 1 writes 0x12345678 to 0x0020 -> mem_wdata_oe=1 and mem_rnw=0 throughout BUSY, req_ready=10, one-cycle RELEASE gap.
REQ-035 Contention: req_en=11 held for 4 transactions -> with macro grants 01,10,01,10; without macro 01,01,01,01.
REQ-036 Timeout: TIMEOUT=4, mem_ready stuck 0 -> timeout_err and req_ready pulse at 4th BUSY cycle, req_rdata=0.
REQ-037 Reset mid-BUSY: rst low during wait -> all outputs at reset values immediately, no req_ready pulse; subsequent read completes normally.
REQ-038 Withdrawal: requester 0 drops req_en in BUSY, addr0 changes to 0x0044 -> mem_addr stays 0x0010, req_ready=01 still pulses.
